// File: rtl/fsb16_pkg.sv
// Constants shared by the FSB16 bridge-side blocks: AHB transfer codes and the
// request arbiter FSM encoding.
package fsb16_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } fsb_state_e;

endpackage

// File: rtl/fsb16_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the requester just
// after the last grant and wraps, producing a one-hot grant.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     gnt
);

  logic             found_s;
  logic             take_s;
  logic [PTR_W-1:0] idx_s;

  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_s      = PTR_W'((int'(last) + k) % N);
      take_s     = !found_s && req[idx_s];
      gnt[idx_s] = gnt[idx_s] | take_s;
      found_s    = found_s | take_s;
    end
  end

endmodule

// File: rtl/fsb16_req_arbiter.sv
// Shares the AHB->FSB16 bridge between NREQ requesters: round-robin grant,
// one single-beat NONSEQ transfer at a time, response return and timeout guard.
module fsb16_req_arbiter
  import fsb16_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [3*NREQ-1:0]    req_size,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [64*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_gnt,
  output logic [NREQ-1:0]      req_done,
  output logic                 rsp_err,
  output logic [63:0]          rsp_rdata,
  output logic                 hsel,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [31:0]          haddr,
  output logic [63:0]          hwdata,
  input  logic                 hready,
  input  logic                 hresp,
  input  logic [63:0]          hrdata,
  output logic                 busy,
  output logic                 timeout_flag
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  fsb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d, arb_gnt_s;
  logic [PTR_W-1:0] owner_q, owner_d, ptr_q, ptr_d, arb_idx_s;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic             hsel_q, hsel_d;
  logic [1:0]       htrans_q, htrans_d;
  logic [TO_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
  logic             err_q, err_d, to_flag_q, to_flag_d;

  rr_arbiter #(.N(NREQ), .PTR_W(PTR_W)) u_rr (
    .req  (req_valid),
    .last (ptr_q),
    .gnt  (arb_gnt_s)
  );

  always_comb begin
    arb_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx_s = arb_gnt_s[i] ? PTR_W'(i) : arb_idx_s;
    end
  end

  assign cnt_inc_s = cnt_q + TO_W'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    write_d   = write_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    to_flag_d = to_flag_q;
    done_d    = '0;
    err_d     = 1'b0;
    hsel_d    = 1'b0;
    htrans_d  = HTRANS_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          gnt_d    = arb_gnt_s;
          owner_d  = arb_idx_s;
          write_d  = req_write[arb_idx_s];
          size_d   = req_size[int'(arb_idx_s)*3 +: 3];
          addr_d   = req_addr[int'(arb_idx_s)*32 +: 32];
          wdata_d  = req_wdata[int'(arb_idx_s)*64 +: 64];
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ISSUE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An error response wins even when hready is also set.
        if (hresp) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (hready) begin
          done_d  = gnt_q;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_inc_s == TO_W'(TIMEOUT)) begin
          cnt_d     = cnt_inc_s;
          done_d    = gnt_q;
          err_d     = 1'b1;
          to_flag_d = 1'b1;
          gnt_d     = '0;
          state_d   = ST_DRAIN;
        end else begin
          cnt_d     = cnt_inc_s;
        end
      end
      ST_RESP: begin
        if (!write_q) begin
          rdata_d = hrdata;
        end else begin
          rdata_d = rdata_q;
        end
        gnt_d   = '0;
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // The abandoned bridge transfer must finish before the bus is reused.
        if (hready || hresp) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      cnt_q     <= '0;
      to_flag_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      hsel_q    <= 1'b0;
      htrans_q  <= HTRANS_IDLE;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      to_flag_q <= to_flag_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hsel_q    <= hsel_d;
      htrans_q  <= htrans_d;
    end
  end

  // Read data arrives in the done cycle itself, so it bypasses the hold register then.
  assign rsp_rdata    = (state_q == ST_RESP && !write_q) ? hrdata : rdata_q;
  assign req_gnt      = gnt_q;
  assign req_done     = done_q;
  assign rsp_err      = err_q;
  assign hsel         = hsel_q;
  assign htrans       = htrans_q;
  assign hwrite       = write_q;
  assign hsize        = size_q;
  assign haddr        = addr_q;
  assign hwdata       = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_flag = to_flag_q;

endmodule

// File: tb/tb_fsb16_req_arbiter.sv
// Self-checking bench: directed and random transfers checked cycle by cycle
// against a transfer-level model of grant order, latency, data and timeout.
module tb_fsb16_req_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 8;

  logic                hclk = 1'b0;
  logic                hreset_n;
  logic [NREQ-1:0]     req_valid, req_write, req_gnt, req_done;
  logic [3*NREQ-1:0]   req_size;
  logic [32*NREQ-1:0]  req_addr;
  logic [64*NREQ-1:0]  req_wdata;
  logic                rsp_err, hsel, hwrite, hready, hresp, busy, timeout_flag;
  logic [63:0]         rsp_rdata, hwdata, hrdata;
  logic [1:0]          htrans;
  logic [2:0]          hsize;
  logic [31:0]         haddr;

  int          checks = 0;
  int          errors = 0;
  int          ptr_m  = 0;
  logic [63:0] rdata_m = 64'd0;
  logic        flag_m  = 1'b0;

  fsb16_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_gnt(req_gnt), .req_done(req_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [63:0] wd);
    req_valid[i]         = 1'b1;
    req_write[i]         = wr;
    req_size[i*3 +: 3]   = sz;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*64 +: 64] = wd;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
  endtask

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(req_gnt), 64'd0);
    chk({tag, "_done"}, 64'(req_done), 64'd0);
    chk({tag, "_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_hsel"}, 64'(hsel), 64'd0);
    chk({tag, "_htrans"}, 64'(htrans), 64'd0);
    chk({tag, "_hwrite"}, 64'(hwrite), 64'd0);
    chk({tag, "_hsize"}, 64'(hsize), 64'd0);
    chk({tag, "_haddr"}, 64'(haddr), 64'd0);
    chk({tag, "_hwdata"}, hwdata, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_flag"}, 64'(timeout_flag), 64'd0);
  endtask

  // Called in an IDLE cycle with requests already driven. The bridge answers
  // in WAIT cycle dly (counted from 0); dly >= TIMEOUT answers during DRAIN.
  task automatic xfer(input int dly, input bit eresp, input bit renew, input logic [63:0] rdv);
    int              w;
    logic [NREQ-1:0] oh;
    logic [31:0]     a;
    logic [63:0]     wd;
    logic            wr;
    logic [2:0]      sz;
    w = pick();
    if (w < 0) begin
      errors++;
      $display("FAIL xfer_setup no requester valid");
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    a  = req_addr[w*32 +: 32];
    wd = req_wdata[w*64 +: 64];
    wr = req_write[w];
    sz = req_size[w*3 +: 3];
    cyc();
    hready = 1'($urandom_range(0, 1));
    hresp  = 1'($urandom_range(0, 1));
    hrdata = {$urandom, $urandom};
    #1;
    chk("issue_gnt", 64'(req_gnt), 64'(oh));
    chk("issue_hsel", 64'(hsel), 64'd1);
    chk("issue_htrans", 64'(htrans), 64'h2);
    chk("issue_haddr", 64'(haddr), 64'(a));
    chk("issue_hwdata", hwdata, wd);
    chk("issue_hwrite", 64'(hwrite), 64'(wr));
    chk("issue_hsize", 64'(hsize), 64'(sz));
    chk("issue_busy", 64'(busy), 64'd1);
    for (int k = 0; k < TIMEOUT; k++) begin
      cyc();
      hready = (k == dly);
      hresp  = (k == dly) && eresp;
      hrdata = {$urandom, $urandom};
      #1;
      chk("wait_hsel", 64'(hsel), 64'd0);
      chk("wait_htrans", 64'(htrans), 64'd0);
      chk("wait_haddr", 64'(haddr), 64'(a));
      chk("wait_hwdata", hwdata, wd);
      chk("wait_gnt", 64'(req_gnt), 64'(oh));
      chk("wait_done", 64'(req_done), 64'd0);
      if (k == dly) break;
    end
    cyc();
    if (dly < TIMEOUT) begin
      hready = 1'($urandom_range(0, 1));
      hresp  = 1'($urandom_range(0, 1));
      hrdata = rdv;
      #1;
      if (!wr) rdata_m = rdv;
      chk("resp_done", 64'(req_done), 64'(oh));
      chk("resp_err", 64'(rsp_err), 64'(eresp));
      chk("resp_rdata", rsp_rdata, rdata_m);
      chk("resp_gnt", 64'(req_gnt), 64'(oh));
      chk("resp_haddr", 64'(haddr), 64'(a));
      chk("resp_htrans", 64'(htrans), 64'd0);
      ptr_m = w;
    end else begin
      hready = (dly == TIMEOUT);
      hresp  = 1'b0;
      hrdata = {$urandom, $urandom};
      #1;
      flag_m = 1'b1;
      chk("to_done", 64'(req_done), 64'(oh));
      chk("to_err", 64'(rsp_err), 64'd1);
      chk("to_flag", 64'(timeout_flag), 64'd1);
      chk("to_gnt", 64'(req_gnt), 64'd0);
      chk("to_busy", 64'(busy), 64'd1);
      chk("to_rdata", rsp_rdata, rdata_m);
    end
    if (renew) rand_req(w);
    else req_valid[w] = 1'b0;
    for (int j = 1; j <= dly - TIMEOUT; j++) begin
      cyc();
      hready = (j == dly - TIMEOUT);
      hresp  = 1'b0;
      hrdata = {$urandom, $urandom};
      #1;
      chk("drain_gnt", 64'(req_gnt), 64'd0);
      chk("drain_done", 64'(req_done), 64'd0);
      chk("drain_htrans", 64'(htrans), 64'd0);
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_haddr", 64'(haddr), 64'(a));
    end
    cyc();
    hready = 1'b0;
    hresp  = 1'b0;
    hrdata = {$urandom, $urandom};
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_gnt", 64'(req_gnt), 64'd0);
    chk("idle_done", 64'(req_done), 64'd0);
    chk("idle_hsel", 64'(hsel), 64'd0);
    chk("idle_rdata", rsp_rdata, rdata_m);
    chk("idle_flag", 64'(timeout_flag), 64'(flag_m));
  endtask

  initial begin
    hreset_n  = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    hready    = 1'b0;
    hresp     = 1'b0;
    hrdata    = 64'd0;
    #2 hreset_n = 1'b0;
    #1 chk_zero("por");
    repeat (2) @(posedge hclk);
    @(negedge hclk) hreset_n = 1'b1;
    cyc();
    #1;
    chk("post_por_hsel", 64'(hsel), 64'd0);
    chk("post_por_busy", 64'(busy), 64'd0);

    // single read from requester 0
    set_req(0, 1'b0, 3'd1, 32'h0000_1006, 64'd0);
    xfer(0, 1'b0, 1'b0, 64'hBEEF_BEEF_BEEF_BEEF);

    // write with hresp and hready together
    set_req(1, 1'b1, 3'd2, 32'h0000_2008, 64'h1122_3344_5566_7788);
    xfer(2, 1'b1, 1'b0, 64'hDEAD_0000_DEAD_0000);

    // both requesters continuously valid: grants alternate 0,1,0,1
    rand_req(0);
    rand_req(1);
    xfer(1, 1'b0, 1'b1, {$urandom, $urandom});
    xfer(3, 1'b0, 1'b1, {$urandom, $urandom});
    xfer(0, 1'b0, 1'b1, {$urandom, $urandom});
    xfer(5, 1'b0, 1'b0, {$urandom, $urandom});

    // timeout on requester 0 with requester 1 waiting through the drain
    rand_req(1);
    xfer(TIMEOUT + 5, 1'b0, 1'b0, 64'd0);
    xfer(2, 1'b0, 1'b0, {$urandom, $urandom});

    // random delays, errors and request patterns
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_req(i);
      end
      if (req_valid == '0) rand_req(int'($urandom_range(0, NREQ - 1)));
      xfer(int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    // asynchronous reset in the middle of WAIT
    req_valid = '0;
    rand_req(0);
    cyc();
    cyc();
    cyc();
    #1 hreset_n = 1'b0;
    #1 chk_zero("mid_wait_rst");
    req_valid = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk) hreset_n = 1'b1;
    ptr_m   = 0;
    rdata_m = 64'd0;
    flag_m  = 1'b0;
    cyc();
    #1;
    chk("post_rst_hsel", 64'(hsel), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_gnt", 64'(req_gnt), 64'd0);

    // pointer back at 0: requester 1 wins first
    rand_req(0);
    rand_req(1);
    xfer(3, 1'b0, 1'b0, {$urandom, $urandom});
    xfer(1, 1'b0, 1'b0, {$urandom, $urandom});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
